lo_ssp_mod: RTL and testbench

Low-frequency modulation path from the ARM to the antenna, carrying data in the opposite direction to the LF read serializer. The block is the SSP clock and frame master. It clocks bytes out of the ARM on `ssp_dout`, buffers them in a 4-entry FIFO, and replays them MSB-first as on/off keying on `pwr_lo`. Each bit lasts `16*(divisor+1)` `pck0` cycles. The block sits in the FPGA LF mode mux, alongside the LF read path.

---
 rtl/lo_pkg.sv | 9 +
 rtl/lo_byte_fifo.sv | 46 ++++
 rtl/lo_ssp_mod.sv | 146 ++++++++++++++
 tb/tb_lo_ssp_mod.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lo_pkg.sv
// Shared constants and FSM state types for the LF modulation (ARM -> antenna) path.
package lo_pkg;
  localparam int FIFO_DEPTH   = 4;
  localparam int BIT_PRESCALE = 16;
  localparam int SSP_BITS     = 8;

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND}  tx_state_e;
endpackage

// File: rtl/lo_byte_fifo.sv
// Byte FIFO between the SSP receiver and the OOK transmitter; push and pop may share an edge.
module lo_byte_fifo import lo_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [SSP_BITS-1:0] wdata_i,
  input  logic                pop_i,
  output logic [SSP_BITS-1:0] rdata_o,
  output logic                empty_o,
  output logic [CW-1:0]       count_o
);
  logic [SSP_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;
  logic                full, do_pop;

  assign full    = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      if (push_i && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !push_i) cnt_q <= cnt_q - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full));
endmodule

// File: rtl/lo_ssp_mod.sv
// SSP master that pulls bytes from the ARM and replays them MSB-first as OOK on pwr_lo.
module lo_ssp_mod #(
  parameter int FIFO_DEPTH   = lo_pkg::FIFO_DEPTH,
  parameter int BIT_PRESCALE = lo_pkg::BIT_PRESCALE
) (
  input  logic       pck0,
  input  logic       reset,
  input  logic       ssp_dout,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  input  logic [7:0] divisor,
  input  logic       mod_en,
  output logic       pwr_lo,
  output logic       pwr_hi,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       underrun,
  output logic       dbg
);
  import lo_pkg::*;

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = $clog2(BIT_PRESCALE * 256);

  logic                sclk_q, rx_arm_q;
  rx_state_e           rx_st_q, rx_st_d;
  logic [3:0]          rx_cnt_q, rx_cnt_d;
  logic [SSP_BITS-1:0] rx_sh_q, rx_sh_d;
  tx_state_e           tx_st_q, tx_st_d;
  logic [2:0]          bit_q, bit_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d, bit_len_m1;
  logic [SSP_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                underrun_q, underrun_d;
  logic                push, pop, empty;
  logic [SSP_BITS-1:0] head;
  logic [CW-1:0]       count;

  lo_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(pck0), .rst_i(reset), .push_i(push), .wdata_i(rx_sh_q),
    .pop_i(pop), .rdata_o(head), .empty_o(empty), .count_o(count)
  );

  // Loading the timer at each bit start is what latches divisor per bit.
  assign bit_len_m1 = TMR_W'(BIT_PRESCALE * (int'(divisor) + 1) - 1);

  // sclk_q==0 before an edge marks a rise edge; rx_arm_q holds off the very first rise.
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_sh_d  = rx_sh_q;
    push     = 1'b0;
    case (rx_st_q)
      RX_IDLE:
        if (rx_arm_q && !sclk_q && count != CW'(FIFO_DEPTH)) begin
          rx_st_d  = RX_SHIFT;
          rx_cnt_d = '0;
        end
      default:
        if (sclk_q) begin
          rx_sh_d  = {rx_sh_q[SSP_BITS-2:0], ssp_dout};
          rx_cnt_d = rx_cnt_q + 4'd1;
        end else if (rx_cnt_q == 4'd8) begin
          push    = 1'b1;
          rx_st_d = RX_IDLE;
        end
    endcase
  end

  always_comb begin
    tx_st_d    = tx_st_q;
    bit_d      = bit_q;
    tmr_d      = tmr_q;
    tx_sh_d    = tx_sh_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    case (tx_st_q)
      TX_IDLE:
        if (mod_en && !empty) begin
          pop     = 1'b1;
          tx_st_d = TX_SEND;
          tx_sh_d = head;
          bit_d   = '0;
          tmr_d   = bit_len_m1;
        end
      default:
        if (!mod_en) begin
          tx_st_d = TX_IDLE;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (bit_q != 3'd7) begin
          bit_d   = bit_q + 3'd1;
          tx_sh_d = {tx_sh_q[SSP_BITS-2:0], 1'b0};
          tmr_d   = bit_len_m1;
        end else if (!empty) begin
          pop     = 1'b1;
          tx_sh_d = head;
          bit_d   = '0;
          tmr_d   = bit_len_m1;
        end else begin
          tx_st_d    = TX_IDLE;
          underrun_d = 1'b1;
        end
    endcase
  end

  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      sclk_q     <= 1'b0;
      rx_arm_q   <= 1'b0;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      tx_st_q    <= TX_IDLE;
      bit_q      <= '0;
      tmr_q      <= '0;
      tx_sh_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      sclk_q     <= ~sclk_q;
      rx_arm_q   <= 1'b1;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_st_q    <= tx_st_d;
      bit_q      <= bit_d;
      tmr_q      <= tmr_d;
      tx_sh_q    <= tx_sh_d;
      underrun_q <= underrun_d;
    end
  end

  assign ssp_clk   = sclk_q;
  assign ssp_frame = rx_st_q == RX_SHIFT;
  assign pwr_lo    = (tx_st_q == TX_SEND) & tx_sh_q[SSP_BITS-1];
  assign dbg       = tx_st_q == TX_SEND;
  assign underrun  = underrun_q;
  assign ssp_din   = 1'b0;
  assign pwr_hi    = 1'b0;
  assign pwr_oe1   = 1'b0;
  assign pwr_oe2   = 1'b0;
  assign pwr_oe3   = 1'b0;
  assign pwr_oe4   = 1'b0;
endmodule

// File: tb/tb_lo_ssp_mod.sv
// Bench for lo_ssp_mod: ARM byte source, timestamp/queue reference model, negedge monitor.
module tb_lo_ssp_mod;
  localparam int DEPTH = 4;
  localparam int PRE   = 16;

  logic       pck0 = 1'b0;
  logic       reset = 1'b1;
  logic       ssp_dout = 1'b0;
  logic [7:0] divisor = 8'd0;
  logic       mod_en = 1'b0;
  logic       ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi;
  logic       pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, underrun, dbg;

  lo_ssp_mod #(.FIFO_DEPTH(DEPTH), .BIT_PRESCALE(PRE)) dut (
    .pck0(pck0), .reset(reset), .ssp_dout(ssp_dout), .ssp_clk(ssp_clk),
    .ssp_frame(ssp_frame), .ssp_din(ssp_din), .divisor(divisor), .mod_en(mod_en),
    .pwr_lo(pwr_lo), .pwr_hi(pwr_hi), .pwr_oe1(pwr_oe1), .pwr_oe2(pwr_oe2),
    .pwr_oe3(pwr_oe3), .pwr_oe4(pwr_oe4), .underrun(underrun), .dbg(dbg)
  );

  always #5 pck0 = ~pck0;

  // Directed byte list consumed by the ARM before it falls back to random bytes.
  logic [7:0] dir [4];
  int         dir_len = 0, dir_base = 0;

  // ARM side: bytes it sends are the stimulus; each one is queued as expected data.
  logic [7:0] sb_q [$];
  int         arm_n = 0;
  initial begin
    bit         in_frame;
    logic [7:0] cur;
    int         idx, k;
    in_frame = 0; cur = 0; idx = -1;
    forever begin
      @(posedge pck0);
      #1;
      if (reset) begin
        sb_q.delete();
        in_frame = 0;
        ssp_dout = 1'b0;
      end else if (!ssp_frame) begin
        in_frame = 0;
      end else if (ssp_clk) begin
        if (!in_frame) begin
          k   = arm_n - dir_base;
          cur = (k >= 0 && k < dir_len) ? dir[k[1:0]] : 8'($urandom);
          arm_n++;
          sb_q.push_back(cur);
          in_frame = 1;
          idx = 7;
        end
        if (idx >= 0) begin
          ssp_dout = cur[idx];
          idx--;
        end
      end
    end
  end

  // Reference model: edge index since release, byte queue, absolute bit end times.
  int         e = 0, m_fs = -1, m_bit = 0, m_bend = 0, rd_i = 0;
  bit         m_busy = 0, m_under = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] mq [$];
  initial begin
    int         cnt;
    bit         do_push, do_pop;
    logic [7:0] nb;
    forever begin
      @(posedge pck0 or posedge reset);
      if (reset) begin
        e = 0; m_fs = -1; m_busy = 0; m_under = 0; m_bit = 0; m_bend = 0;
        m_byte = 8'h00; rd_i = 0; mq.delete();
      end else begin
        e++;
        cnt = mq.size(); do_push = 0; do_pop = 0;
        if (m_fs >= 0) begin
          if (e == m_fs + 16) begin do_push = 1; m_fs = -1; end
        end else if (e % 2 == 1 && e >= 3 && cnt < DEPTH) begin
          m_fs = e;
        end
        m_under = 0;
        if (!m_busy) begin
          if (mod_en && cnt > 0) do_pop = 1;
        end else if (!mod_en) begin
          m_busy = 0;
        end else if (e == m_bend) begin
          if (m_bit > 0) begin
            m_bit--;
            m_bend = e + PRE * (int'(divisor) + 1);
          end else if (cnt > 0) begin
            do_pop = 1;
          end else begin
            m_busy = 0; m_under = 1;
          end
        end
        if (do_pop) begin
          m_byte = mq.pop_front();
          m_busy = 1; m_bit = 7;
          m_bend = e + PRE * (int'(divisor) + 1);
        end
        if (do_push) begin
          nb = (rd_i < sb_q.size()) ? sb_q[rd_i] : 8'h00;
          rd_i++;
          mq.push_back(nb);
        end
      end
    end
  end

  int vectors = 0, miscompares = 0;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", nm, act, exp, e, $time);
    end
  endtask

  // Monitor: outputs settle after posedge, compared on negedge (also while reset is held).
  initial begin
    forever begin
      @(negedge pck0);
      chk("ssp_frame", 8'(ssp_frame), 8'(m_fs >= 0));
      chk("ssp_clk",   8'(ssp_clk),   8'(e % 2 == 1));
      chk("pwr_lo",    8'(pwr_lo),    8'(m_busy && m_byte[m_bit]));
      chk("dbg",       8'(dbg),       8'(m_busy));
      chk("underrun",  8'(underrun),  8'(m_under));
      chk("tieoff", 8'({ssp_din, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4}), 8'h00);
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge pck0);
    #2;
  endtask

  // Reset lands mid-cycle so the negedge check sees the asynchronous clear.
  task automatic do_reset();
    @(posedge pck0);
    #3 reset = 1'b1;
    repeat (2) @(posedge pck0);
    #2 reset = 1'b0;
  endtask

  initial begin
    int r;
    dir[0] = 8'hA5; dir[1] = 8'hC3; dir[2] = 8'h81; dir[3] = 8'h3C;
    dir_len = 4; dir_base = 0;
    run(3);
    reset = 1'b0;
    run(120);                       // fill FIFO with mod_en low, then frames stop
    mod_en = 1'b1; divisor = 8'd0;
    run(600);                       // A5, C3, 81, 3C at 16 cycles/bit

    do_reset();
    dir[0] = 8'hFF; dir[1] = 8'h00; dir_len = 2; dir_base = arm_n;
    divisor = 8'd2;
    run(900);                       // 384 high then 384 low, RX refilling meanwhile

    divisor = 8'd0; run(40);
    divisor = 8'd3; run(200);       // mid-bit change applies from the next bit
    run(50); mod_en = 1'b0; run(2); mod_en = 1'b1;
    run(300);                       // abort then restart from next byte

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      do_reset();
      else if (r < 3)  mod_en = ~mod_en;
      else if (r < 6)  divisor = 8'($urandom_range(0, 5));
      run($urandom_range(10, 300));
    end
    mod_en = 1'b1;
    run(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
